alp_seq_alu: RTL

- Parametrised, multi-nibble successor to the 4-bit ALP ALU slice.
- Binary and BCD add/subtract, with the decimal adjust applied per nibble across the full word.
- Adds sequential operations the combinational slice cannot perform: iterative unsigned multiply, restoring divide and a multi-cycle rotate, under a start/busy/done handshake with abort.
- Sits between the A/B operand muxes and the W bus in the wide data path; registers its result and flags.

---
 rtl/alp_seq_alu.sv | 333 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alp_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : alp_seq_alu
// Purpose  : Parametrised multi-nibble ALU. It performs binary and BCD
//            add/subtract in one cycle, plus iterative unsigned multiply,
//            restoring divide and bit-serial rotate-left. Operations start on
//            a start/busy/done handshake and can be aborted.
//            The result and flags are registered and change only when an
//            operation completes.
// Ports    : clk         - datapath clock, rising edge
//            reset_l     - asynchronous active-low reset
//            start_h     - operation request (accepted only when idle)
//            abort_h     - cancels an in-progress multi-cycle operation
//            op_h        - operation select, sampled with start_h
//            amux_h      - operand A, sampled with start_h
//            bmux_h      - operand B, sampled with start_h
//            carry_in_h  - carry/borrow-in for the add/sub operations
//            busy_h      - multi-cycle operation in progress
//            done_h      - one-cycle pulse when result and flags update
//            result_h    - primary result
//            aux_h       - secondary result (product high / remainder)
//            c_out_h     - carry-out / decimal carry
//            v_out_h     - overflow / divide-by-zero
//            z_out_h     - result_h == 0
//            n_out_h     - result_h MSB
// Revision : 1.0 - initial release
// ============================================================================
module alp_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic             abort_h,
  input  logic [2:0]       op_h,
  input  logic [WIDTH-1:0] amux_h,
  input  logic [WIDTH-1:0] bmux_h,
  input  logic             carry_in_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [WIDTH-1:0] result_h,
  output logic [WIDTH-1:0] aux_h,
  output logic             c_out_h,
  output logic             v_out_h,
  output logic             z_out_h,
  output logic             n_out_h
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_BCDADD = 3'b010;
  localparam logic [2:0] OP_BCDSUB = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_DIV    = 3'b101;
  localparam logic [2:0] OP_ROTL   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  // hi/lo form the iteration register: {product high, multiplier/product low}
  // for MUL, {remainder, dividend/quotient} for DIV, and lo alone for ROTL.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  // --------------------------------------------------------------------------
  // Single-cycle arithmetic on the live operands
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] bcd_add, bcd_sub;
  logic             bcd_add_c, bcd_sub_c;
  logic [4:0]       nib_sum, nib_dif;
  logic             dec_c, dec_b;

  always_comb begin : p_single
    add_sum = {1'b0, amux_h} + {1'b0, bmux_h} + {{WIDTH{1'b0}}, carry_in_h};
    sub_sum = {1'b0, amux_h} + {1'b0, ~bmux_h} + {{WIDTH{1'b0}}, carry_in_h};
    add_v   = (amux_h[WIDTH-1] == bmux_h[WIDTH-1]) &&
              (add_sum[WIDTH-1] != amux_h[WIDTH-1]);
    sub_v   = (amux_h[WIDTH-1] != bmux_h[WIDTH-1]) &&
              (sub_sum[WIDTH-1] != amux_h[WIDTH-1]);
    bcd_add = '0;
    bcd_sub = '0;
    nib_sum = '0;
    nib_dif = '0;
    dec_c   = carry_in_h;
    dec_b   = ~carry_in_h;
    // The decimal carry/borrow ripples nibble by nibble. Non-BCD digits simply
    // follow the same adjust rule, and the result is truncated to 4 bits.
    for (int i = 0; i < WIDTH / 4; i++) begin
      nib_sum = {1'b0, amux_h[4*i +: 4]} + {1'b0, bmux_h[4*i +: 4]} + {4'b0000, dec_c};
      dec_c   = (nib_sum > 5'd9);
      if (dec_c) begin
        nib_sum = nib_sum + 5'd6;
      end
      bcd_add[4*i +: 4] = nib_sum[3:0];

      nib_dif = {1'b0, amux_h[4*i +: 4]} - {1'b0, bmux_h[4*i +: 4]} - {4'b0000, dec_b};
      dec_b   = nib_dif[4];
      if (dec_b) begin
        nib_dif = nib_dif - 5'd6;
      end
      bcd_sub[4*i +: 4] = nib_dif[3:0];
    end
    bcd_add_c = dec_c;
    bcd_sub_c = ~dec_b;
  end

  // ROTL iteration count; a count of zero completes in a single cycle.
  logic [CNTW-1:0] rot_cnt;
  assign rot_cnt = CNTW'(bmux_h % WIDTH);

  // --------------------------------------------------------------------------
  // One iteration step of the latched multi-cycle operation
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   mul_acc, div_shift, div_diff;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  always_comb begin : p_iter
    mul_acc   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    iter_hi   = hi_q;
    iter_lo   = lo_q;
    case (op_q)
      OP_MUL: begin
        // Shift-add: the product shifts right into the spent multiplier bits.
        iter_hi = mul_acc[WIDTH:1];
        iter_lo = {mul_acc[0], lo_q[WIDTH-1:1]};
      end
      OP_DIV: begin
        // The partial remainder is always less than 2*B, so div_diff[WIDTH]
        // is the sign of the trial subtraction.
        if (!div_diff[WIDTH]) begin
          iter_hi = div_diff[WIDTH-1:0];
          iter_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          iter_hi = div_shift[WIDTH-1:0];
          iter_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        iter_lo = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]};
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic             fin_load;
  logic [WIDTH-1:0] fin_res, fin_aux;
  logic             fin_c, fin_v;

  always_comb begin : p_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    fin_load = 1'b0;
    fin_res  = '0;
    fin_aux  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_h) begin
          op_d = op_h;
          b_d  = bmux_h;
          case (op_h)
            OP_ADD: begin
              fin_load = 1'b1;
              fin_res  = add_sum[WIDTH-1:0];
              fin_c    = add_sum[WIDTH];
              fin_v    = add_v;
            end
            OP_SUB: begin
              fin_load = 1'b1;
              fin_res  = sub_sum[WIDTH-1:0];
              fin_c    = sub_sum[WIDTH];
              fin_v    = sub_v;
            end
            OP_BCDADD: begin
              fin_load = 1'b1;
              fin_res  = bcd_add;
              fin_c    = bcd_add_c;
            end
            OP_BCDSUB: begin
              fin_load = 1'b1;
              fin_res  = bcd_sub;
              fin_c    = bcd_sub_c;
            end
            OP_MUL: begin
              hi_d    = '0;
              lo_d    = amux_h;
              cnt_d   = CNTW'(WIDTH);
              state_d = ST_ITER;
            end
            OP_DIV: begin
              if (bmux_h == '0) begin
                fin_load = 1'b1;
                fin_res  = '1;
                fin_aux  = amux_h;
                fin_v    = 1'b1;
              end else begin
                hi_d    = '0;
                lo_d    = amux_h;
                cnt_d   = CNTW'(WIDTH);
                state_d = ST_ITER;
              end
            end
            OP_ROTL: begin
              if (rot_cnt == '0) begin
                fin_load = 1'b1;
                fin_res  = amux_h;
              end else begin
                lo_d    = amux_h;
                cnt_d   = rot_cnt;
                state_d = ST_ITER;
              end
            end
            default: begin
              fin_load = 1'b1;
              fin_res  = amux_h;
            end
          endcase
          if (fin_load) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_ITER: begin
        if (abort_h) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = iter_hi;
          lo_d  = iter_lo;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d  = ST_FIN;
            fin_load = 1'b1;
            fin_res  = iter_lo;
            if (op_q == OP_MUL) begin
              fin_aux = iter_hi;
              fin_v   = |iter_hi;
            end else if (op_q == OP_DIV) begin
              fin_aux = iter_hi;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Visible results only move on the edge that enters FIN.
  always_comb begin : p_result
    result_d = result_q;
    aux_d    = aux_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    n_d      = n_q;
    if (fin_load) begin
      result_d = fin_res;
      aux_d    = fin_aux;
      c_d      = fin_c;
      v_d      = fin_v;
      z_d      = (fin_res == '0);
      n_d      = fin_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin : p_regs
    if (!reset_l) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      aux_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      aux_q    <= aux_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign busy_h   = (state_q == ST_ITER);
  assign done_h   = (state_q == ST_FIN);
  assign result_h = result_q;
  assign aux_h    = aux_q;
  assign c_out_h  = c_q;
  assign v_out_h  = v_q;
  assign z_out_h  = z_q;
  assign n_out_h  = n_q;

endmodule
`default_nettype wire
